// File: rtl/refill_cache_dados.sv
// rtl/refill_cache_dados.sv - read-miss line refill and write-through store buffer for the data cache
module refill_cache_dados #(
    parameter int LINHAS   = 32,
    parameter int PALAVRAS = 4,
    parameter int WB_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       miss_req,
    input  logic [31:0]                miss_addr,
    input  logic                       sw_req,
    input  logic [31:0]                sw_addr,
    input  logic [31:0]                sw_data,
    output logic                       sw_ready,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ack,
    input  logic [31:0]                mem_rdata,
    output logic                       fill_valid,
    output logic [$clog2(LINHAS)-1:0]  fill_index,
    output logic [31-$clog2(LINHAS)-$clog2(PALAVRAS)-2:0] fill_tag,
    output logic [PALAVRAS*32-1:0]     fill_data,
    output logic                       busy
);

    localparam int IDX_W = $clog2(LINHAS);
    localparam int K_W   = $clog2(PALAVRAS);
    localparam int OFF_W = K_W + 2;
    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    localparam logic [K_W-1:0]   K_LAST  = K_W'(PALAVRAS - 1);
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(WB_DEPTH - 1);
    localparam logic [CNT_W-1:0] WB_FULL = CNT_W'(WB_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] REFILL = 2'd2;
    localparam logic [1:0] FILL   = 2'd3;

    logic [1:0]       state;
    logic [31:OFF_W]  lat_line;
    logic [K_W-1:0]   k_q;
    logic [31:0]      line_q [PALAVRAS];

    logic [31:0]      wb_addr [WB_DEPTH];
    logic [31:0]      wb_data [WB_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] wb_count;
    logic             push;
    logic             pop;

    // Byte offset inside a line never selects anything: the whole line is fetched.
    logic unused_offset_bits;
    assign unused_offset_bits = ^miss_addr[OFF_W-1:0];

    // Full buffer refuses the store even if the head drains this same cycle.
    assign sw_ready = (wb_count < WB_FULL);
    assign push     = sw_req && sw_ready;
    assign pop      = (state == DRAIN) && mem_ack;

    assign busy       = (state != IDLE);
    assign fill_valid = (state == FILL);
    assign fill_index = lat_line[IDX_W+OFF_W-1:OFF_W];
    assign fill_tag   = lat_line[31:IDX_W+OFF_W];

    // Flatten the assembled line, word k at bits [32k+31:32k].
    always_comb begin
        fill_data = '0;
        for (int i = 0; i < PALAVRAS; i++) begin
            fill_data[32*i +: 32] = line_q[i];
        end
    end

    // Memory port is driven only in DRAIN and REFILL, so reset drops mem_req at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            DRAIN: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_addr[rd_ptr];
                mem_wdata = wb_data[rd_ptr];
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {lat_line, k_q, 2'b00};
            end
            default: ;
        endcase
    end

    // Store buffer payload; only pointers and count need a reset.
    always_ff @(posedge clock) begin
        if (push) begin
            wb_addr[wr_ptr] <= sw_addr;
            wb_data[wr_ptr] <= sw_data;
        end
    end

    // Store buffer pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            wb_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_END) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_END) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   wb_count <= wb_count + 1'b1;
                2'b01:   wb_count <= wb_count - 1'b1;
                default: wb_count <= wb_count;
            endcase
        end
    end

    // Controller: drain every buffered store before refilling, so a missed line sees prior stores.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lat_line <= '0;
            k_q      <= '0;
            for (int i = 0; i < PALAVRAS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wb_count != '0) begin
                        state <= DRAIN;
                    end else if (miss_req) begin
                        lat_line <= miss_addr[31:OFF_W];
                        k_q      <= '0;
                        state    <= REFILL;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        line_q[k_q] <= mem_rdata;
                        if (k_q == K_LAST) begin
                            state <= FILL;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_refill_cache_dados.sv
// tb/tb_refill_cache_dados.sv - self-checking bench for refill_cache_dados
module tb_refill_cache_dados;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         sw_req = 1'b0;
    logic [31:0]  sw_addr = '0;
    logic [31:0]  sw_data = '0;
    logic         sw_ready;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         fill_valid;
    logic [4:0]   fill_index;
    logic [22:0]  fill_tag;
    logic [127:0] fill_data;
    logic         busy;

    refill_cache_dados dut (
        .clock(clock), .reset(reset),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .sw_req(sw_req), .sw_addr(sw_addr), .sw_data(sw_data), .sw_ready(sw_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag),
        .fill_data(fill_data), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    typedef struct packed {
        logic [4:0]   idx;
        logic [22:0]  tag;
        logic [127:0] data;
    } fill_t;

    typedef struct {
        logic [31:0] addr;
        int          delay;
        logic [4:0]  idx;
        logic [22:0] tag;
    } vec_t;

    xact_t mem_log[$];
    xact_t exp_log[$];
    fill_t fill_log[$];
    fill_t exp_fill[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 0;
    bit hold_ack  = 1'b0;
    int wcnt      = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] p;
        p = a * 32'h9E37_79B1;
        return p ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: acks after ack_delay waiting cycles, logs every completed transfer.
    always @(negedge clock) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (reset && mem_req && !hold_ack) begin
            if (wcnt >= ack_delay) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (mem_we) begin
                    mem_log.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
                end else begin
                    mem_rdata = mem_word(mem_addr);
                    mem_log.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Cache side: record every line write.
    always @(negedge clock) begin
        if (reset && fill_valid) begin
            fill_log.push_back('{idx: fill_index, tag: fill_tag, data: fill_data});
        end
    end

    task automatic model_store(input logic [31:0] a, input logic [31:0] d);
        exp_log.push_back('{we: 1'b1, addr: a, data: d});
    endtask

    task automatic model_miss(input logic [31:0] a);
        logic [127:0] line;
        logic [31:0]  wa;
        logic [31:0]  w;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            wa = {a[31:4], 4'h0} + 32'(4 * k);
            w  = mem_word(wa);
            exp_log.push_back('{we: 1'b0, addr: wa, data: w});
            line[32*k +: 32] = w;
        end
        exp_fill.push_back('{idx: a[8:4], tag: a[31:9], data: line});
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_xact_count"}, 128'(mem_log.size()), 128'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < mem_log.size(); i++) begin
            check({tag, "_xact"}, 128'(mem_log[i]), 128'(exp_log[i]));
        end
        check({tag, "_fill_count"}, 128'(fill_log.size()), 128'(exp_fill.size()));
        for (int i = 0; i < exp_fill.size() && i < fill_log.size(); i++) begin
            check({tag, "_fill_index"}, 128'(fill_log[i].idx), 128'(exp_fill[i].idx));
            check({tag, "_fill_tag"}, 128'(fill_log[i].tag), 128'(exp_fill[i].tag));
            check({tag, "_fill_data"}, fill_log[i].data, exp_fill[i].data);
        end
        mem_log.delete();
        exp_log.delete();
        fill_log.delete();
        exp_fill.delete();
    endtask

    // All drivers start and end on a falling edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        sw_req = 1'b1; sw_addr = a; sw_data = d;
        for (int i = 0; i < 400 && !ok; i++) begin
            ok = sw_ready;
            @(negedge clock);
        end
        sw_req = 1'b0;
        check("store_accept", 128'(ok), 128'(1));
    endtask

    task automatic do_miss(input logic [31:0] a, input int n_pre, input bit extra,
                           input logic [31:0] ea, input logic [31:0] ed, output int cap_edge);
        bit seen;
        bit pend;
        seen = 1'b0;
        pend = extra;
        cap_edge = 0;
        miss_req = 1'b1; miss_addr = a;
        for (int i = 1; i <= 600 && !seen; i++) begin
            @(negedge clock);
            if (sw_req) sw_req = 1'b0;
            if (mem_log.size() > n_pre) begin
                miss_addr = $urandom;
                if (pend) begin
                    sw_req = 1'b1; sw_addr = ea; sw_data = ed; pend = 1'b0;
                end
            end
            if (fill_valid) begin
                seen = 1'b1;
                cap_edge = i + 1;
                miss_req = 1'b0;
            end
        end
        sw_req = 1'b0;
        miss_req = 1'b0;
        check("fill_seen", 128'(seen), 128'(1));
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clock);
            done = !busy && (mem_log.size() >= exp_log.size());
        end
        check("drain_done", 128'(done), 128'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[5];
        int    cap;
        int    nst;
        bit    extra;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ea;
        logic [31:0] ed;

        vt[0] = '{addr: 32'h0000_1234, delay: 2, idx: 5'd3,  tag: 23'h9};
        vt[1] = '{addr: 32'h0000_0040, delay: 0, idx: 5'd4,  tag: 23'h0};
        vt[2] = '{addr: 32'hFFFF_FFF0, delay: 1, idx: 5'd31, tag: 23'h7F_FFFF};
        vt[3] = '{addr: 32'h8000_0400, delay: 0, idx: 5'd0,  tag: 23'h40_0002};
        vt[4] = '{addr: 32'h0000_01F8, delay: 3, idx: 5'd31, tag: 23'h0};

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            sw_req = 1'($urandom); miss_req = 1'($urandom);
            sw_addr = $urandom; sw_data = $urandom; miss_addr = $urandom;
            #1;
            check("reset_flags", {123'd0, mem_req, fill_valid, busy, sw_ready, mem_we}, 128'b00010);
            check("reset_data", {mem_addr, mem_wdata, 64'd0} | 128'(fill_data), 128'd0);
        end
        @(negedge clock);
        sw_req = 1'b0; miss_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clock);
        check("idle_no_traffic", 128'(mem_log.size()), 128'd0);
        check("idle_not_busy", 128'(busy), 128'd0);

        // Three back-to-back stores against a stalled memory.
        hold_ack = 1'b1;
        model_store(32'h100, 32'hAA); model_store(32'h104, 32'hBB); model_store(32'h108, 32'hCC);
        sw_req = 1'b1; sw_addr = 32'h100; sw_data = 32'hAA;
        @(negedge clock);
        sw_addr = 32'h104; sw_data = 32'hBB;
        @(negedge clock);
        sw_addr = 32'h108; sw_data = 32'hCC;
        check("wb_full_ready", 128'(sw_ready), 128'd0);
        @(negedge clock);
        check("wb_full_held", 128'(sw_ready), 128'd0);
        check("drain_head", {mem_req, mem_we, mem_addr, mem_wdata}, {62'd0, 1'b1, 1'b1, 32'h100, 32'hAA});
        @(negedge clock);
        check("drain_head_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {62'd0, 1'b1, 1'b1, 32'h100, 32'hAA});
        hold_ack = 1'b0;
        do_store(32'h108, 32'hCC);
        wait_idle();
        compare_logs("store_order");

        // Buffered store must reach memory before the refill reads.
        ack_delay = 1;
        model_store(32'h200, 32'h55);
        model_miss(32'h400);
        do_store(32'h200, 32'h55);
        do_miss(32'h400, 1, 1'b0, 32'h0, 32'h0, cap);
        wait_idle();
        compare_logs("raw_order");

        // Reset after the second refill ack.
        ack_delay = 0;
        miss_req = 1'b1; miss_addr = 32'h800;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(posedge clock);
                #1;
                got = (mem_log.size() >= 2);
            end
            check("reset_mid_reached", 128'(got), 128'd1);
        end
        reset = 1'b0;
        #1;
        check("reset_mid_req", {126'd0, mem_req, busy}, 128'd0);
        miss_req = 1'b0;
        @(negedge clock);
        check("reset_mid_fill", 128'(fill_valid), 128'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clock);
        check("reset_mid_fills", 128'(fill_log.size()), 128'd0);
        check("reset_mid_reads", 128'(mem_log.size()), 128'd2);
        mem_log.delete();
        fill_log.delete();
        model_miss(32'h800);
        do_miss(32'h800, 0, 1'b0, 32'h0, 32'h0, cap);
        wait_idle();
        compare_logs("restart");

        // Zero-wait memory: fill captured on the sixth edge, no second refill.
        ack_delay = 0;
        model_miss(32'h40);
        do_miss(32'h40, 0, 1'b0, 32'h0, 32'h0, cap);
        check("fill_latency", 128'(cap), 128'd6);
        for (int i = 0; i < 10; i++) @(negedge clock);
        compare_logs("latency");

        // Table of miss addresses with hand-derived index and tag.
        for (int v = 0; v < 5; v++) begin
            ack_delay = vt[v].delay;
            model_miss(vt[v].addr);
            do_miss(vt[v].addr, 0, 1'b0, 32'h0, 32'h0, cap);
            wait_idle();
            check("table_fill_count", 128'(fill_log.size()), 128'd1);
            if (fill_log.size() > 0) begin
                check("table_index", 128'(fill_log[0].idx), 128'(vt[v].idx));
                check("table_tag", 128'(fill_log[0].tag), 128'(vt[v].tag));
            end
            compare_logs("table");
        end

        // Random stores, misses and stores issued mid-refill.
        for (int it = 0; it < 20; it++) begin
            ack_delay = $urandom_range(0, 3);
            nst = $urandom_range(0, 3);
            extra = 1'($urandom_range(0, 1));
            for (int s = 0; s < nst; s++) begin
                a = $urandom & 32'hFFFF_FFFC;
                d = $urandom;
                model_store(a, d);
                do_store(a, d);
            end
            a = $urandom;
            ea = $urandom & 32'hFFFF_FFFC;
            ed = $urandom;
            model_miss(a);
            if (extra) model_store(ea, ed);
            do_miss(a, nst, extra, ea, ed, cap);
            wait_idle();
            compare_logs("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
